ipv4_arp_lut_learn: RTL and testbench

//  Write-side initiator for the IPv4 ARP table: takes learned (IPv4, MAC) bindings from the ARP-reply parser and

---
 rtl/ipv4_arp_lut_learn_pkg.sv | 16 +
 rtl/ipv4_arp_learn_shadow.sv | 78 +++++++
 rtl/ipv4_arp_lut_learn.sv | 159 +++++++++++++++
 tb/tb_ipv4_arp_lut_learn.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_arp_lut_learn_pkg.sv
// Shared ARP learn constants: MAC width, row bits, eth padding, FSM states.
// Used by ipv4_arp_lut_learn and its shadow; mirrors the table's sizing.
package ipv4_arp_lut_learn_pkg;

  localparam int LRN_ROWS      = 32;
  localparam int LRN_ROW_BITS  = 5;
  localparam int LRN_MAC_WIDTH = 48;
  localparam int LRN_ETH_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SCAN       = 2'd1,
    ST_WRITE_WAIT = 2'd2
  } learn_st_e;

endpackage

// File: rtl/ipv4_arp_learn_shadow.sv
// Shadow of the ARP table valid/IPv4 columns with a one-row-per-cycle scan.
// In: scan, ip, set/set_row/set_ip, flush. Out: hit, free, row, done.
module ipv4_arp_learn_shadow
  import ipv4_arp_lut_learn_pkg::*;
#(
  parameter int ROWS     = LRN_ROWS,
  parameter int ROW_BITS = LRN_ROW_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                scan,
  input  logic [31:0]         ip,
  input  logic                set,
  input  logic [ROW_BITS-1:0] set_row,
  input  logic [31:0]         set_ip,
  input  logic                flush,
  output logic                hit,
  output logic                free,
  output logic [ROW_BITS-1:0] row,
  output logic                done
);

  logic [ROWS-1:0]     vld_q;
  logic [31:0]         ip_q [ROWS];
  logic [ROW_BITS-1:0] idx_q;
  logic [ROW_BITS-1:0] hit_row_q;
  logic [ROW_BITS-1:0] free_row_q;
  logic                hit_q;
  logic                free_q;
  logic                cur_hit;
  logic                cur_free;
  logic [ROW_BITS-1:0] hit_row;
  logic [ROW_BITS-1:0] free_row;

  assign cur_hit  = vld_q[idx_q] && (ip_q[idx_q] == ip);
  assign cur_free = !vld_q[idx_q];

  // Fold in the row under the index so the last scan cycle sees all rows.
  assign hit      = hit_q | cur_hit;
  assign free     = free_q | cur_free;
  assign hit_row  = hit_q ? hit_row_q : idx_q;
  assign free_row = free_q ? free_row_q : idx_q;
  assign row      = hit ? hit_row : free_row;
  assign done     = scan && (idx_q == ROW_BITS'(ROWS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q      <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      free_q     <= 1'b0;
      hit_row_q  <= '0;
      free_row_q <= '0;
      for (int i = 0; i < ROWS; i++) ip_q[i] <= '0;
    end else begin
      if (flush) vld_q <= '0;
      else if (set) vld_q[set_row] <= 1'b1;
      if (set) ip_q[set_row] <= set_ip;

      if (!scan) begin
        idx_q  <= '0;
        hit_q  <= 1'b0;
        free_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
        if (cur_hit && !hit_q) begin
          hit_q     <= 1'b1;
          hit_row_q <= idx_q;
        end
        if (cur_free && !free_q) begin
          free_q     <= 1'b1;
          free_row_q <= idx_q;
        end
      end
    end
  end

endmodule

// File: rtl/ipv4_arp_lut_learn.sv
// ARP learn write initiator: picks hit/free/round-robin row, drives wr_req/ack.
// Ports: learn valid/ready bus, flush, table write port, four stat counters.
module ipv4_arp_lut_learn
  import ipv4_arp_lut_learn_pkg::*;
#(
  parameter int IPV4_ARP_LUT_ROWS     = LRN_ROWS,
  parameter int IPV4_ARP_LUT_ROW_BITS = LRN_ROW_BITS,
  parameter int MAC_WIDTH             = LRN_MAC_WIDTH,
  parameter int ACK_TIMEOUT           = 64
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             i_learn_valid,
  output logic                             o_learn_ready,
  input  logic [31:0]                      i_learn_ipv4,
  input  logic [MAC_WIDTH-1:0]             i_learn_eth,
  input  logic                             i_flush,
  output logic                             o_ipv4_arp_lut_wr_req,
  input  logic                             i_ipv4_arp_lut_wr_ack,
  output logic [IPV4_ARP_LUT_ROW_BITS-1:0] o_ipv4_arp_lut_wr_addr,
  output logic [LRN_ETH_W-1:0]             o_ipv4_arp_lut_wr_eth_addr,
  output logic [31:0]                      o_ipv4_arp_lut_wr_ipv4_addr,
  output logic [31:0]                      o_learn_cnt,
  output logic [31:0]                      o_evict_cnt,
  output logic [31:0]                      o_drop_cnt,
  output logic [31:0]                      o_err_cnt
);

  localparam int ROWS = IPV4_ARP_LUT_ROWS;
  localparam int RB   = IPV4_ARP_LUT_ROW_BITS;

  learn_st_e   state_q;
  learn_st_e   state_d;
  logic        flush_pend;
  logic        evict_q;
  logic [RB-1:0] rr_q;
  logic [15:0] tcnt_q;

  logic          in_idle;
  logic          in_ww;
  logic          accept;
  logic          filt;
  logic          ack;
  logic          tout;
  logic          flush_now;
  logic          sh_hit;
  logic          sh_free;
  logic          sh_done;
  logic [RB-1:0] sh_row;
  logic [RB-1:0] sel_row;
  logic          evict;

  assign in_idle = (state_q == ST_IDLE);
  assign in_ww   = (state_q == ST_WRITE_WAIT);

  // Gated by resetn so ready stays low while reset is held.
  assign o_learn_ready = resetn && in_idle && !flush_pend;

  assign accept = o_learn_ready && i_learn_valid;
  // Zero IP or group MAC (I/G bit of first octet) is never learned.
  assign filt   = (i_learn_ipv4 == 32'd0) || i_learn_eth[40];

  assign ack  = in_ww && i_ipv4_arp_lut_wr_ack;
  assign tout = in_ww && !i_ipv4_arp_lut_wr_ack &&
                (tcnt_q == 16'(ACK_TIMEOUT - 1));

  assign flush_now = in_idle && (i_flush || flush_pend);

  assign evict   = !(sh_hit || sh_free);
  assign sel_row = evict ? rr_q : sh_row;

  ipv4_arp_learn_shadow #(
    .ROWS     (ROWS),
    .ROW_BITS (RB)
  ) u_shadow (
    .clk     (clk),
    .resetn  (resetn),
    .scan    (state_q == ST_SCAN),
    .ip      (o_ipv4_arp_lut_wr_ipv4_addr),
    // A flush seen with the ack leaves the row invalid.
    .set     (ack && !i_flush),
    .set_row (o_ipv4_arp_lut_wr_addr),
    .set_ip  (o_ipv4_arp_lut_wr_ipv4_addr),
    .flush   (flush_now),
    .hit     (sh_hit),
    .free    (sh_free),
    .row     (sh_row),
    .done    (sh_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (accept && !filt) state_d = ST_SCAN;
      ST_SCAN:       if (sh_done) state_d = ST_WRITE_WAIT;
      ST_WRITE_WAIT: if (ack || tout) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q                     <= ST_IDLE;
      flush_pend                  <= 1'b0;
      evict_q                     <= 1'b0;
      rr_q                        <= '0;
      tcnt_q                      <= '0;
      o_ipv4_arp_lut_wr_req       <= 1'b0;
      o_ipv4_arp_lut_wr_addr      <= '0;
      o_ipv4_arp_lut_wr_eth_addr  <= '0;
      o_ipv4_arp_lut_wr_ipv4_addr <= '0;
      o_learn_cnt                 <= '0;
      o_evict_cnt                 <= '0;
      o_drop_cnt                  <= '0;
      o_err_cnt                   <= '0;
    end else begin
      state_q <= state_d;

      if (accept && filt) o_drop_cnt <= o_drop_cnt + 1'b1;

      // Write-port data doubles as the latched binding used by the scan.
      if (accept && !filt) begin
        o_ipv4_arp_lut_wr_ipv4_addr <= i_learn_ipv4;
        o_ipv4_arp_lut_wr_eth_addr  <=
          {{(LRN_ETH_W - MAC_WIDTH){1'b0}}, i_learn_eth};
      end

      if (sh_done) begin
        o_ipv4_arp_lut_wr_req  <= 1'b1;
        o_ipv4_arp_lut_wr_addr <= sel_row;
        evict_q                <= evict;
        tcnt_q                 <= '0;
      end

      if (in_ww) begin
        if (ack || tout) o_ipv4_arp_lut_wr_req <= 1'b0;
        else tcnt_q <= tcnt_q + 1'b1;
      end

      if (ack) begin
        o_learn_cnt <= o_learn_cnt + 1'b1;
        if (evict_q) begin
          o_evict_cnt <= o_evict_cnt + 1'b1;
          rr_q <= (rr_q == RB'(ROWS - 1)) ? '0 : rr_q + 1'b1;
        end
      end

      if (tout) o_err_cnt <= o_err_cnt + 1'b1;

      if (flush_now) begin
        rr_q       <= '0;
        flush_pend <= 1'b0;
      end else if (i_flush && !in_idle) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ipv4_arp_lut_learn.sv
// Self-checking bench for ipv4_arp_lut_learn: directed cases plus random
// learns against a table-level reference model (ACK_TIMEOUT=16).
module tb_ipv4_arp_lut_learn;

  localparam int ROWS = 32;
  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_learn_valid = 1'b0;
  logic        o_learn_ready;
  logic [31:0] i_learn_ipv4 = '0;
  logic [47:0] i_learn_eth = '0;
  logic        i_flush = 1'b0;
  logic        wr_req;
  logic        wr_ack = 1'b0;
  logic [4:0]  wr_addr;
  logic [63:0] wr_eth;
  logic [31:0] wr_ip;
  logic [31:0] learn_cnt, evict_cnt, drop_cnt, err_cnt;

  always #5 clk = ~clk;

  ipv4_arp_lut_learn #(
    .ACK_TIMEOUT (TOUT)
  ) dut (
    .clk                         (clk),
    .resetn                      (resetn),
    .i_learn_valid               (i_learn_valid),
    .o_learn_ready               (o_learn_ready),
    .i_learn_ipv4                (i_learn_ipv4),
    .i_learn_eth                 (i_learn_eth),
    .i_flush                     (i_flush),
    .o_ipv4_arp_lut_wr_req       (wr_req),
    .i_ipv4_arp_lut_wr_ack       (wr_ack),
    .o_ipv4_arp_lut_wr_addr      (wr_addr),
    .o_ipv4_arp_lut_wr_eth_addr  (wr_eth),
    .o_ipv4_arp_lut_wr_ipv4_addr (wr_ip),
    .o_learn_cnt                 (learn_cnt),
    .o_evict_cnt                 (evict_cnt),
    .o_drop_cnt                  (drop_cnt),
    .o_err_cnt                   (err_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference table: valid/IPv4 per row, victim pointer, stats.
  bit          mv [ROWS];
  logic [31:0] mi [ROWS];
  int          m_rr;
  logic [31:0] m_learn, m_evict, m_drop, m_err;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear_table();
    for (int r = 0; r < ROWS; r++) mv[r] = 1'b0;
    m_rr = 0;
  endtask

  task automatic model_reset();
    model_clear_table();
    m_learn = 0;
    m_evict = 0;
    m_drop  = 0;
    m_err   = 0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_learn"}, learn_cnt, m_learn);
    chk({tag, "_evict"}, evict_cnt, m_evict);
    chk({tag, "_drop"}, drop_cnt, m_drop);
    chk({tag, "_err"}, err_cnt, m_err);
  endtask

  task automatic do_reset();
    i_learn_valid = 1'b0;
    i_flush = 1'b0;
    wr_ack = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    model_reset();
    chk("rst_req", wr_req, 0);
    chk("rst_rdy", o_learn_ready, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_eth", wr_eth, 0);
    chk("rst_ip", wr_ip, 0);
    chk_cnt("rst");
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_rdy_rel", o_learn_ready, 1);
  endtask

  // mode: 0 ack, 1 no ack (timeout), 2 flush during scan,
  //       3 flush together with ack, 4 reset while waiting for ack
  task automatic learn(input logic [31:0] ip, input logic [47:0] mac,
                       input int mode);
    int  n;
    int  h;
    int  row;
    int  dly;
    bit  ev;
    bit  filt;
    @(negedge clk);
    i_learn_valid = 1'b1;
    i_learn_ipv4  = ip;
    i_learn_eth   = mac;
    n = 0;
    while (!o_learn_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_learn_ready) begin
      chk("ready_timeout", 0, 1);
      i_learn_valid = 1'b0;
      return;
    end
    filt = (ip == 32'd0) || mac[40];
    row = -1;
    ev  = 1'b0;
    for (int r = 0; r < ROWS; r++)
      if (row < 0 && mv[r] && mi[r] == ip) row = r;
    for (int r = 0; r < ROWS; r++)
      if (row < 0 && !mv[r]) row = r;
    if (row < 0) begin
      row = m_rr;
      ev  = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    i_learn_valid = 1'b0;
    if (filt) begin
      m_drop++;
      chk("drop_rdy", o_learn_ready, 1);
      chk("drop_req", wr_req, 0);
      chk_cnt("drop");
      return;
    end
    n = 1;
    while (!wr_req && n < 100) begin
      i_flush = (mode == 2 && n == 5);
      @(negedge clk);
      n++;
    end
    i_flush = 1'b0;
    chk("req_latency", n, ROWS + 1);
    chk("wr_addr", wr_addr, row);
    chk("wr_eth", wr_eth, {16'h0, mac});
    chk("wr_ip", wr_ip, ip);
    if (mode == 4) begin
      resetn = 1'b0;
      #1;
      model_reset();
      chk("rst_ww_req", wr_req, 0);
      chk("rst_ww_rdy", o_learn_ready, 0);
      chk_cnt("rst_ww");
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      return;
    end
    if (mode == 1) begin
      h = 0;
      while (wr_req && h < 100) begin
        @(negedge clk);
        h++;
      end
      m_err++;
      chk("tout_len", h, TOUT);
      chk_cnt("tout");
      return;
    end
    dly = $urandom_range(0, 3);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      chk("req_hold", wr_req, 1);
    end
    wr_ack  = 1'b1;
    i_flush = (mode == 3);
    @(negedge clk);
    wr_ack  = 1'b0;
    i_flush = 1'b0;
    chk("ack_drop", wr_req, 0);
    m_learn++;
    if (ev) begin
      m_evict++;
      m_rr = (m_rr + 1) % ROWS;
    end
    mv[row] = 1'b1;
    mi[row] = ip;
    if (mode == 2 || mode == 3) model_clear_table();
    chk_cnt("ack");
  endtask

  initial begin
    logic [31:0] ip;
    logic [47:0] mac;
    int r;
    int md;

    do_reset();

    learn(32'h0A00_0001, 48'h0011_2233_4455, 0);
    chk("t1_eth", wr_eth, 64'h0000_0011_2233_4455);
    chk("t1_learn", learn_cnt, 1);
    learn(32'h0A00_0001, 48'h0000_0000_00AA, 0);
    chk("t2_addr", wr_addr, 0);
    chk("t2_evict", evict_cnt, 0);

    do_reset();
    for (int i = 0; i < 34; i++)
      learn(32'h0B00_0000 + i, 48'h0200_0000_0000 + i, 0);
    chk("t3_addr", wr_addr, 1);
    chk("t3_evict", evict_cnt, 2);

    learn(32'h0, 48'h0011_2233_4455, 0);
    learn(32'h0C00_0001, 48'h0100_5E00_0001, 0);
    chk("t4_drop", drop_cnt, 2);

    do_reset();
    learn(32'h0D00_0001, 48'h0000_1111_2222, 1);
    learn(32'h0D00_0001, 48'h0000_1111_2222, 0);
    chk("t5_addr", wr_addr, 0);

    do_reset();
    for (int i = 0; i < 3; i++)
      learn(32'h0E00_0000 + i + 1, 48'h0000_0000_0100 + i, 0);
    learn(32'h0E00_0010, 48'h0000_0000_0200, 2);
    learn(32'h0E00_0020, 48'h0000_0000_0300, 0);
    chk("t6_addr", wr_addr, 0);
    learn(32'h0E00_0030, 48'h0000_0000_0400, 3);
    learn(32'h0E00_0020, 48'h0000_0000_0500, 0);
    learn(32'h0E00_0040, 48'h0000_0000_0600, 4);

    do_reset();
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 99);
      ip = 32'hC0A8_0000 + $urandom_range(1, 40);
      mac = {16'($urandom), $urandom};
      mac[40] = 1'b0;
      if (r < 5) ip = 32'h0;
      else if (r < 10) mac[40] = 1'b1;
      r = $urandom_range(0, 99);
      md = (r < 6) ? 1 : (r < 9) ? 2 : (r < 11) ? 3 : 0;
      learn(ip, mac, md);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
